cpu_bus_master: RTL and testbench

//  Parametrised two-channel bus master between CPU core and memory/IO bus.

---
 rtl/cpu_bus_master_pkg.sv | 15 +
 rtl/cpu_bus_master_arbiter.sv | 38 +++
 rtl/cpu_bus_master.sv | 176 +++++++++++++++++
 tb/tb_cpu_bus_master.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_master_pkg.sv
// rtl/cpu_bus_master_pkg.sv - shared state codes for the CPU bus master
package cpu_bus_master_pkg;

    localparam int IO_STATE_W = 3;

    typedef enum logic [IO_STATE_W-1:0] {
        io_idle        = 3'd0,
        io_read_begin  = 3'd1,
        io_read_wait   = 3'd2,
        io_write_begin = 3'd3,
        io_write_wait  = 3'd4,
        io_abort       = 3'd5
    } io_state_e;

endpackage

// File: rtl/cpu_bus_master_arbiter.sv
// rtl/cpu_bus_master_arbiter.sv - two-way fetch/data grant, fixed or round-robin
module bus_arbiter2 #(
    parameter int ARB_MODE = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic if_req,
    input  logic d_req,
    input  logic accept,
    output logic gnt_valid,
    output logic gnt_d
);

    // Points at the channel that wins the next conflict; starts on data.
    logic prefer_d_q, prefer_d_d;

    always_comb begin
        gnt_valid = if_req | d_req;
        if (if_req && d_req) begin
            gnt_d = (ARB_MODE == 0) ? 1'b1 : prefer_d_q;
        end else begin
            gnt_d = d_req;
        end
        prefer_d_d = prefer_d_q;
        if (accept && gnt_valid) begin
            prefer_d_d = ~gnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prefer_d_q <= 1'b1;
        end else begin
            prefer_d_q <= prefer_d_d;
        end
    end

endmodule

// File: rtl/cpu_bus_master.sv
// rtl/cpu_bus_master.sv - fetch/data bus master with begin/wait handshake and timeout
module cpu_bus_master
    import cpu_bus_master_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16,
    parameter int ARB_MODE   = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic                    if_done,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_be,
    output logic                    d_done,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    err,
    output logic [ADDR_WIDTH-1:0]   bus_addr,
    output logic [DATA_WIDTH-1:0]   bus_wdata,
    output logic [DATA_WIDTH/8-1:0] bus_be,
    output logic                    bus_read,
    output logic                    bus_write,
    input  logic                    bus_ready,
    input  logic [DATA_WIDTH-1:0]   bus_rdata,
    output logic [2:0]              io_state
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    io_state_e             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  gnt_d_q, gnt_d_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0]       be_q, be_d;
    logic                  bus_read_q, bus_read_d;
    logic                  bus_write_q, bus_write_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  if_done_q, if_done_d;
    logic                  d_done_q, d_done_d;
    logic                  accept;
    logic                  arb_valid, arb_gnt_d;

    bus_arbiter2 #(
        .ARB_MODE(ARB_MODE)
    ) u_arb (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .d_req    (d_req),
        .accept   (accept),
        .gnt_valid(arb_valid),
        .gnt_d    (arb_gnt_d)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gnt_d_d     = gnt_d_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        bus_read_d  = 1'b0;
        bus_write_d = 1'b0;
        if_done_d   = 1'b0;
        d_done_d    = 1'b0;
        accept      = 1'b0;
        case (state_q)
            io_idle: begin
                // The done cycle still sees the finished op's request; skip it.
                if (arb_valid && !(if_done_q || d_done_q)) begin
                    accept  = 1'b1;
                    gnt_d_d = arb_gnt_d;
                    if (arb_gnt_d) begin
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                        be_d    = d_be;
                    end else begin
                        addr_d = if_addr;
                    end
                    if (arb_gnt_d && d_we) begin
                        state_d     = io_write_begin;
                        bus_write_d = 1'b1;
                    end else begin
                        state_d    = io_read_begin;
                        bus_read_d = 1'b1;
                    end
                end
            end
            io_read_begin: begin
                cnt_d   = '0;
                state_d = io_read_wait;
            end
            io_write_begin: begin
                cnt_d   = '0;
                state_d = io_write_wait;
            end
            io_read_wait, io_write_wait: begin
                if (bus_ready) begin
                    if (state_q == io_read_wait) begin
                        rdata_d = bus_rdata;
                    end
                    err_d     = 1'b0;
                    if_done_d = ~gnt_d_q;
                    d_done_d  = gnt_d_q;
                    state_d   = io_idle;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    state_d = io_abort;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            io_abort: begin
                rdata_d   = '0;
                err_d     = 1'b1;
                if_done_d = ~gnt_d_q;
                d_done_d  = gnt_d_q;
                state_d   = io_idle;
            end
            default: state_d = io_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= io_idle;
            cnt_q       <= '0;
            gnt_d_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            bus_read_q  <= 1'b0;
            bus_write_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gnt_d_q     <= gnt_d_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            bus_read_q  <= bus_read_d;
            bus_write_q <= bus_write_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            if_done_q   <= if_done_d;
            d_done_q    <= d_done_d;
        end
    end

    assign io_state  = state_q;
    assign if_done   = if_done_q;
    assign d_done    = d_done_q;
    assign rdata     = rdata_q;
    assign err       = err_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign bus_be    = be_q;
    assign bus_read  = bus_read_q;
    assign bus_write = bus_write_q;

endmodule

// File: tb/tb_cpu_bus_master.sv
// tb/tb_cpu_bus_master.sv - directed bench; three instances with different timeout/arbitration
module tb_cpu_bus_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  if_req = '0, d_req = '0, d_we = '0, bus_ready = '0;
    logic [31:0] if_addr [3], d_addr [3], d_wdata [3], bus_rdata [3];
    logic [3:0]  d_be [3];
    wire  [2:0]  if_done, d_done, err, bus_read, bus_write;
    wire  [31:0] rdata [3], bus_addr [3], bus_wdata [3];
    wire  [3:0]  bus_be [3];
    wire  [2:0]  io_state [3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Instance 0: fixed priority, TIMEOUT=16. 1: round-robin, TIMEOUT=4. 2: TIMEOUT=0.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        cpu_bus_master #(
            .ADDR_WIDTH(32),
            .DATA_WIDTH(32),
            .TIMEOUT   ((g == 0) ? 16 : ((g == 1) ? 4 : 0)),
            .ARB_MODE  ((g == 1) ? 1 : 0)
        ) dut (
            .clk      (clk),
            .reset    (reset),
            .if_req   (if_req[g]),
            .if_addr  (if_addr[g]),
            .if_done  (if_done[g]),
            .d_req    (d_req[g]),
            .d_we     (d_we[g]),
            .d_addr   (d_addr[g]),
            .d_wdata  (d_wdata[g]),
            .d_be     (d_be[g]),
            .d_done   (d_done[g]),
            .rdata    (rdata[g]),
            .err      (err[g]),
            .bus_addr (bus_addr[g]),
            .bus_wdata(bus_wdata[g]),
            .bus_be   (bus_be[g]),
            .bus_read (bus_read[g]),
            .bus_write(bus_write[g]),
            .bus_ready(bus_ready[g]),
            .bus_rdata(bus_rdata[g]),
            .io_state (io_state[g])
        );
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (io_state[k] !== 3'd0) begin
                errors++; $display("FAIL reset_state[%0d]: got %0d expected 0", k, io_state[k]);
            end
            checks++;
            if ({bus_read[k], bus_write[k], if_done[k], d_done[k], err[k]} !== 5'b0) begin
                errors++; $display("FAIL reset_flags[%0d]: got %b expected 00000", k,
                    {bus_read[k], bus_write[k], if_done[k], d_done[k], err[k]});
            end
            checks++;
            if ({rdata[k], bus_addr[k], bus_wdata[k], bus_be[k]} !== 100'b0) begin
                errors++; $display("FAIL reset_data[%0d]: got %h/%h expected 0/0", k, rdata[k], bus_addr[k]);
            end
        end
    endtask

    task automatic test_fetch_read();
        if_addr[0] = 32'h100; if_req[0] = 1'b1;
        step();
        checks++;
        if ({io_state[0], bus_read[0], bus_write[0]} !== {3'd1, 2'b10} || bus_addr[0] !== 32'h100) begin
            errors++; $display("FAIL fetch_begin: got st=%0d rd=%b wr=%b addr=%h expected st=1 rd=1 wr=0 addr=100",
                io_state[0], bus_read[0], bus_write[0], bus_addr[0]);
        end
        bus_ready[0] = 1'b1; bus_rdata[0] = 32'hDEADBEEF;
        step();
        checks++;
        if (io_state[0] !== 3'd2 || bus_read[0] !== 1'b0 || if_done[0] !== 1'b0) begin
            errors++; $display("FAIL fetch_wait: got st=%0d rd=%b done=%b expected st=2 rd=0 done=0",
                io_state[0], bus_read[0], if_done[0]);
        end
        step();
        checks++;
        if ({if_done[0], d_done[0], err[0]} !== 3'b100 || rdata[0] !== 32'hDEADBEEF || io_state[0] !== 3'd0) begin
            errors++; $display("FAIL fetch_done: got done=%b%b err=%b rdata=%h st=%0d expected 10 0 deadbeef 0",
                if_done[0], d_done[0], err[0], rdata[0], io_state[0]);
        end
        if_req[0] = 1'b0; bus_ready[0] = 1'b0;
        step();
        checks++;
        if (if_done[0] !== 1'b0 || rdata[0] !== 32'hDEADBEEF || io_state[0] !== 3'd0) begin
            errors++; $display("FAIL fetch_hold: got done=%b rdata=%h st=%0d expected 0 deadbeef 0",
                if_done[0], rdata[0], io_state[0]);
        end
    endtask

    task automatic test_store_wait();
        d_addr[0] = 32'h200; d_wdata[0] = 32'h12345678; d_be[0] = 4'hF; d_we[0] = 1'b1; d_req[0] = 1'b1;
        step();
        checks++;
        if (io_state[0] !== 3'd3 || bus_write[0] !== 1'b1 || bus_read[0] !== 1'b0
            || bus_addr[0] !== 32'h200 || bus_wdata[0] !== 32'h12345678 || bus_be[0] !== 4'hF) begin
            errors++; $display("FAIL store_begin: got st=%0d wr=%b addr=%h wdata=%h be=%h expected 3 1 200 12345678 f",
                io_state[0], bus_write[0], bus_addr[0], bus_wdata[0], bus_be[0]);
        end
        step();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (io_state[0] !== 3'd4 || bus_write[0] !== 1'b0 || bus_addr[0] !== 32'h200 || d_done[0] !== 1'b0) begin
                errors++; $display("FAIL store_wait%0d: got st=%0d wr=%b addr=%h done=%b expected 4 0 200 0",
                    i, io_state[0], bus_write[0], bus_addr[0], d_done[0]);
            end
            if (i == 4) bus_ready[0] = 1'b1;
            step();
        end
        checks++;
        if ({d_done[0], if_done[0], err[0]} !== 3'b100 || io_state[0] !== 3'd0 || bus_addr[0] !== 32'h200) begin
            errors++; $display("FAIL store_done: got done=%b%b err=%b st=%0d addr=%h expected 10 0 0 200",
                d_done[0], if_done[0], err[0], io_state[0], bus_addr[0]);
        end
        d_req[0] = 1'b0; d_we[0] = 1'b0; bus_ready[0] = 1'b0;
        step();
    endtask

    task automatic test_fixed_priority();
        if_addr[0] = 32'h400; d_addr[0] = 32'h300; d_we[0] = 1'b0;
        if_req[0] = 1'b1; d_req[0] = 1'b1; bus_ready[0] = 1'b1; bus_rdata[0] = 32'h0000_3333;
        step();
        checks++;
        if (bus_addr[0] !== 32'h300 || io_state[0] !== 3'd1) begin
            errors++; $display("FAIL fixed_grant_d: got addr=%h st=%0d expected 300 1", bus_addr[0], io_state[0]);
        end
        step(); step();
        checks++;
        if ({d_done[0], if_done[0]} !== 2'b10 || rdata[0] !== 32'h0000_3333) begin
            errors++; $display("FAIL fixed_done_d: got done=%b%b rdata=%h expected 10 00003333",
                d_done[0], if_done[0], rdata[0]);
        end
        d_req[0] = 1'b0; bus_rdata[0] = 32'h0000_4444;
        step();
        checks++;
        if (io_state[0] !== 3'd0) begin
            errors++; $display("FAIL fixed_gap: got st=%0d expected 0", io_state[0]);
        end
        step();
        checks++;
        if (bus_addr[0] !== 32'h400 || io_state[0] !== 3'd1) begin
            errors++; $display("FAIL fixed_grant_i: got addr=%h st=%0d expected 400 1", bus_addr[0], io_state[0]);
        end
        step(); step();
        checks++;
        if ({d_done[0], if_done[0]} !== 2'b01 || rdata[0] !== 32'h0000_4444) begin
            errors++; $display("FAIL fixed_done_i: got done=%b%b rdata=%h expected 01 00004444",
                d_done[0], if_done[0], rdata[0]);
        end
        if_req[0] = 1'b0; bus_ready[0] = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_read();
        if_addr[0] = 32'h600; if_req[0] = 1'b1; bus_ready[0] = 1'b0;
        step(); step();
        checks++;
        if (io_state[0] !== 3'd2) begin
            errors++; $display("FAIL rst_mid_setup: got st=%0d expected 2", io_state[0]);
        end
        reset = 1'b1;
        step();
        checks++;
        if (io_state[0] !== 3'd0 || {bus_read[0], bus_write[0], if_done[0], d_done[0]} !== 4'b0 || rdata[0] !== 32'h0) begin
            errors++; $display("FAIL rst_mid: got st=%0d flags=%b rdata=%h expected 0 0000 0",
                io_state[0], {bus_read[0], bus_write[0], if_done[0], d_done[0]}, rdata[0]);
        end
        if_req[0] = 1'b0; reset = 1'b0;
        step(); step();
        checks++;
        if (if_done[0] !== 1'b0 || io_state[0] !== 3'd0) begin
            errors++; $display("FAIL rst_mid_after: got done=%b st=%0d expected 0 0", if_done[0], io_state[0]);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] seq;
        int n, last, cyc;
        seq = '0; n = 0; last = 0; cyc = 0;
        if_addr[1] = 32'h1000; d_addr[1] = 32'h2000; d_we[1] = 1'b0;
        bus_rdata[1] = 32'hA5A5A5A5; bus_ready[1] = 1'b1;
        if_req[1] = 1'b1; d_req[1] = 1'b1;
        while (n < 4 && cyc < 40) begin
            step();
            cyc++;
            if (if_done[1] || d_done[1]) begin
                checks++;
                if (if_done[1] && d_done[1]) begin
                    errors++; $display("FAIL rr_both_done: got 11 expected one-hot at cycle %0d", cyc);
                end
                checks++;
                if (cyc - last !== ((n == 0) ? 3 : 4)) begin
                    errors++; $display("FAIL rr_spacing%0d: got %0d expected %0d", n, cyc - last, (n == 0) ? 3 : 4);
                end
                seq[n] = d_done[1];
                last = cyc;
                n++;
            end
        end
        if_req[1] = 1'b0; d_req[1] = 1'b0; bus_ready[1] = 1'b0;
        checks++;
        if (n !== 4 || seq !== 4'b0101) begin
            errors++; $display("FAIL rr_order: got n=%0d seq=%b expected n=4 seq=0101 (D,I,D,I)", n, seq);
        end
        step();
    endtask

    task automatic test_timeout();
        int w;
        w = 0;
        d_addr[1] = 32'h3000; d_we[1] = 1'b0; bus_ready[1] = 1'b0; d_req[1] = 1'b1;
        step();
        checks++;
        if (io_state[1] !== 3'd1 || bus_read[1] !== 1'b1) begin
            errors++; $display("FAIL to_begin: got st=%0d rd=%b expected 1 1", io_state[1], bus_read[1]);
        end
        step();
        while (io_state[1] === 3'd2 && w < 20) begin
            w++;
            step();
        end
        checks++;
        if (w !== 4 || io_state[1] !== 3'd5 || d_done[1] !== 1'b0) begin
            errors++; $display("FAIL to_abort: got waits=%0d st=%0d done=%b expected 4 5 0", w, io_state[1], d_done[1]);
        end
        step();
        checks++;
        if ({d_done[1], if_done[1], err[1]} !== 3'b101 || rdata[1] !== 32'h0 || io_state[1] !== 3'd0) begin
            errors++; $display("FAIL to_done: got done=%b%b err=%b rdata=%h st=%0d expected 10 1 0 0",
                d_done[1], if_done[1], err[1], rdata[1], io_state[1]);
        end
        d_req[1] = 1'b0;
        step();
    endtask

    task automatic test_no_timeout();
        d_addr[2] = 32'h4000; d_wdata[2] = 32'hCAFEF00D; d_be[2] = 4'h3; d_we[2] = 1'b1;
        bus_ready[2] = 1'b0; d_req[2] = 1'b1;
        step(); step();
        for (int i = 0; i < 100; i++) begin
            checks++;
            if (io_state[2] !== 3'd4 || d_done[2] !== 1'b0) begin
                errors++; $display("FAIL nto_wait%0d: got st=%0d done=%b expected 4 0", i, io_state[2], d_done[2]);
                break;
            end
            if (i == 99) bus_ready[2] = 1'b1;
            step();
        end
        checks++;
        if ({d_done[2], err[2]} !== 2'b10 || io_state[2] !== 3'd0 || bus_be[2] !== 4'h3) begin
            errors++; $display("FAIL nto_done: got done=%b err=%b st=%0d be=%h expected 1 0 0 3",
                d_done[2], err[2], io_state[2], bus_be[2]);
        end
        d_req[2] = 1'b0; d_we[2] = 1'b0; bus_ready[2] = 1'b0;
        step();
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            if_addr[k] = '0; d_addr[k] = '0; d_wdata[k] = '0; d_be[k] = '0; bus_rdata[k] = '0;
        end
        step(); step();
        test_reset();
        reset = 1'b0;
        step();
        test_fetch_read();
        test_store_wait();
        test_fixed_priority();
        test_reset_mid_read();
        test_round_robin();
        test_timeout();
        test_no_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
